// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Handles the hazards forwarding cannot cover: load-use, branch/JALR
// operands produced by a load, and multi-cycle data-memory accesses.
// It also keeps a sticky memory-timeout flag and a saturating count of
// stall cycles.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             branch_ID,
    input  logic             redirect_ID,
    input  logic [4:0]       rd_EX,
    input  logic [4:0]       rd_MEM,
    input  logic             MemRead_EX,
    input  logic             MemRead_MEM,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             bubble_EX,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             bubble_WB,
    output logic             flush_ID,
    output logic [1:0]       hz_state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Last wait_cnt value before the timeout flag sets.
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    state_t      ret_q;
    state_t      ret_d;
    logic [15:0] wait_cnt_q;
    logic        enter_wait;
    logic        freeze;
    logic        hold;
    logic        flush;
    logic        memwait;
    logic        lu;
    logic        bl_mem;

    // True when a register written by an older instruction is read in ID.
    function automatic logic dep(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2
    );
        return (rd != 5'd0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

    assign memwait = dmem_req_MEM && !dmem_ready;
    assign lu      = MemRead_EX && dep(rd_EX, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID);
    assign bl_mem  = branch_ID && MemRead_MEM &&
                     dep(rd_MEM, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID);

    // Next-state and hazard decision; freeze = memory wait, hold = ID stall + bubble.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        enter_wait = 1'b0;
        freeze     = 1'b0;
        hold       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            RUN: begin
                if (memwait) begin
                    freeze     = 1'b1;
                    ret_d      = RUN;
                    state_d    = MEM_WAIT;
                    enter_wait = 1'b1;
                end else if (lu || bl_mem) begin
                    hold = 1'b1;
                    // A branch on a load in EX needs a second stall cycle.
                    if (lu && branch_ID) begin
                        state_d = BR_WAIT;
                    end
                end else if (redirect_ID) begin
                    flush = 1'b1;
                end
            end
            BR_WAIT: begin
                if (memwait) begin
                    freeze     = 1'b1;
                    ret_d      = BR_WAIT;
                    state_d    = MEM_WAIT;
                    enter_wait = 1'b1;
                end else begin
                    // Unconditional second stall; any redirect is taken later.
                    hold    = 1'b1;
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    freeze = 1'b1;
                end else begin
                    // Exit cycle: pipeline advances, no hazard decision here.
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = RUN;
                ret_d   = RUN;
            end
        endcase
    end

    assign stall_IF  = freeze | hold;
    assign stall_ID  = freeze | hold;
    assign bubble_EX = hold;
    assign stall_EX  = freeze;
    assign stall_MEM = freeze;
    assign bubble_WB = freeze;
    assign flush_ID  = flush & ~(freeze | hold);
    assign hz_state  = state_q;

    // FSM state and return-state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    // Memory wait counter: cleared on entry, counts MEM_WAIT cycles, never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 16'd0;
        end else if (enter_wait) begin
            wait_cnt_q <= 16'd0;
        end else if ((state_q == MEM_WAIT) && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    // Sticky timeout flag; the FSM keeps waiting after it sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_timeout <= 1'b0;
        end else if ((state_q == MEM_WAIT) && !dmem_ready &&
                     (wait_cnt_q == TIMEOUT_LAST)) begin
            mem_timeout <= 1'b1;
        end
    end

    // Saturating count of cycles with the ID stage held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_ID && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: vector table, directed multi-cycle sequences,
// and randomized stimulus against a behavioural model.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] HOLD = 7'b1110000;
    localparam logic [6:0] FRZ  = 7'b1101110;
    localparam logic [6:0] FL   = 7'b0000001;

    logic          clk;
    logic          rst;
    logic [4:0]    rs1_ID, rs2_ID, rd_EX, rd_MEM;
    logic          use_rs1_ID, use_rs2_ID, branch_ID, redirect_ID;
    logic          MemRead_EX, MemRead_MEM, dmem_req_MEM, dmem_ready;
    logic          stall_IF, stall_ID, bubble_EX, stall_EX, stall_MEM, bubble_WB, flush_ID;
    logic [1:0]    hz_state;
    logic          mem_timeout;
    logic [CW-1:0] stall_cycles;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .branch_ID(branch_ID), .redirect_ID(redirect_ID),
        .rd_EX(rd_EX), .rd_MEM(rd_MEM),
        .MemRead_EX(MemRead_EX), .MemRead_MEM(MemRead_MEM),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
        .stall_EX(stall_EX), .stall_MEM(stall_MEM), .bubble_WB(bubble_WB),
        .flush_ID(flush_ID), .hz_state(hz_state),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       redir;
        logic [4:0] rdex;
        logic [4:0] rdmem;
        logic       mrex;
        logic       mrmem;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] ctrl;
        logic [1:0] nxt;
        string      name;
    } vec_t;

    int errs;
    int checks;
    vec_t vq[$];

    // Behavioural model: "waiting" for memory, an owed second branch stall,
    // the wait length so far, the timeout flag and the stall count.
    bit m_wait;
    bit m_owed;
    int m_wcnt;
    bit m_to;
    int m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic br,
                               input logic redir, input logic [4:0] rdex,
                               input logic [4:0] rdmem, input logic mrex,
                               input logic mrmem, input logic req, input logic rdy);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br; v.redir = redir;
        v.rdex = rdex; v.rdmem = rdmem; v.mrex = mrex; v.mrmem = mrmem;
        v.req = req; v.rdy = rdy;
        return v;
    endfunction

    task automatic drive(input in_t v);
        rs1_ID = v.rs1; rs2_ID = v.rs2; use_rs1_ID = v.u1; use_rs2_ID = v.u2;
        branch_ID = v.br; redirect_ID = v.redir; rd_EX = v.rdex; rd_MEM = v.rdmem;
        MemRead_EX = v.mrex; MemRead_MEM = v.mrmem;
        dmem_req_MEM = v.req; dmem_ready = v.rdy;
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {stall_IF, stall_ID, bubble_EX, stall_EX, stall_MEM, bubble_WB, flush_ID};
    endfunction

    function automatic bit reads(input in_t v, input logic [4:0] rd);
        return (rd != 5'd0) && ((v.u1 && rd == v.rs1) || (v.u2 && rd == v.rs2));
    endfunction

    function automatic logic [6:0] model_ctrl(input in_t v);
        bit lu_h, blm_h, mw;
        lu_h  = v.mrex && reads(v, v.rdex);
        blm_h = v.br && v.mrmem && reads(v, v.rdmem);
        mw    = v.req && !v.rdy;
        if (m_wait)               return v.rdy ? NONE : FRZ;
        else if (mw)              return FRZ;
        else if (m_owed)          return HOLD;
        else if (lu_h || blm_h)   return HOLD;
        else if (v.redir)         return FL;
        return NONE;
    endfunction

    function automatic logic [1:0] model_state();
        return m_wait ? 2'd2 : (m_owed ? 2'd1 : 2'd0);
    endfunction

    task automatic model_reset();
        m_wait = 0; m_owed = 0; m_wcnt = 0; m_to = 0; m_cnt = 0;
    endtask

    task automatic model_update(input in_t v, input logic [6:0] c);
        bit lu_h, blm_h;
        lu_h  = v.mrex && reads(v, v.rdex);
        blm_h = v.br && v.mrmem && reads(v, v.rdmem);
        if (c[5] && m_cnt < CNT_MAX) m_cnt++;
        if (m_wait) begin
            if (!v.rdy) begin
                if (m_wcnt == TO - 1) m_to = 1;
                m_wcnt++;
            end else begin
                m_wait = 0;
            end
        end else if (v.req && !v.rdy) begin
            m_wait = 1;
            m_wcnt = 0;
        end else if (m_owed) begin
            m_owed = 0;
        end else if (lu_h || blm_h) begin
            m_owed = lu_h && v.br;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive('0);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input in_t v, input logic [6:0] ec, input logic [1:0] es,
                        input string nm);
        @(negedge clk);
        drive(v);
        #1;
        chk({nm, ".ctrl"}, 32'(dut_ctrl()), 32'(ec));
        chk({nm, ".state"}, 32'(hz_state), 32'(es));
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input in_t v, input logic [6:0] c, input logic [1:0] n,
                        input string nm);
        vec_t e;
        e.in = v; e.ctrl = c; e.nxt = n; e.name = nm;
        vq.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_t idle, lu, brlu, w, wr, lu_w, lu_r, br_mem, rd_only;
        errs = 0;
        checks = 0;
        rst = 1'b1;
        drive('0);
        idle    = '0;
        lu      = mk(5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 5'd0, 1, 0, 0, 0);
        brlu    = mk(5'd7, 5'd0, 1, 0, 1, 1, 5'd7, 5'd0, 1, 0, 0, 0);
        br_mem  = mk(5'd7, 5'd0, 1, 0, 1, 1, 5'd0, 5'd7, 0, 1, 0, 0);
        rd_only = mk(5'd0, 5'd0, 0, 0, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0);
        w       = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 0);
        wr      = mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 1);
        lu_w    = mk(5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 5'd0, 1, 0, 1, 0);
        lu_r    = mk(5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 5'd0, 1, 0, 1, 1);

        // Reset state, checked while rst is still high.
        #2;
        chk("reset.state", 32'(hz_state), 32'd0);
        chk("reset.timeout", 32'(mem_timeout), 32'd0);
        chk("reset.count", 32'(stall_cycles), 32'd0);
        chk("reset.ctrl", 32'(dut_ctrl()), 32'(NONE));

        // Single-cycle decisions from RUN, each after a fresh reset.
        addv(lu, HOLD, 2'd0, "lu_rs1");
        addv(mk(5'd0, 5'd5, 0, 1, 0, 0, 5'd5, 5'd0, 1, 0, 0, 0), HOLD, 2'd0, "lu_rs2");
        addv(mk(5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 5'd0, 1, 0, 0, 0), NONE, 2'd0, "lu_rd0");
        addv(mk(5'd5, 5'd0, 0, 0, 0, 0, 5'd5, 5'd0, 1, 0, 0, 0), NONE, 2'd0, "lu_nouse");
        addv(mk(5'd7, 5'd0, 1, 0, 1, 0, 5'd7, 5'd0, 0, 0, 0, 0), NONE, 2'd0, "br_alu_ex");
        addv(mk(5'd7, 5'd0, 1, 0, 1, 0, 5'd7, 5'd0, 1, 0, 0, 0), HOLD, 2'd1, "br_ld_ex");
        addv(mk(5'd0, 5'd7, 0, 1, 1, 0, 5'd0, 5'd7, 0, 1, 0, 0), HOLD, 2'd0, "br_ld_mem");
        addv(mk(5'd7, 5'd0, 1, 0, 0, 0, 5'd0, 5'd7, 0, 1, 0, 0), NONE, 2'd0, "ld_mem_nobr");
        addv(mk(5'd7, 5'd0, 1, 0, 1, 1, 5'd0, 5'd7, 0, 0, 0, 0), FL, 2'd0, "br_alu_mem");
        addv(rd_only, FL, 2'd0, "redirect");
        addv(mk(5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 5'd0, 1, 0, 0, 0), HOLD, 2'd0, "lu_redir");
        addv(w, FRZ, 2'd2, "memwait");
        addv(lu_r, HOLD, 2'd0, "req_ready_lu");
        addv(lu_w, FRZ, 2'd2, "memwait_lu");
        foreach (vq[i]) begin
            do_reset();
            step(vq[i].in, vq[i].ctrl, 2'd0, vq[i].name);
            chk({vq[i].name, ".next"}, 32'(hz_state), 32'(vq[i].nxt));
        end

        // Load-use: one stall cycle, counted once.
        do_reset();
        step(lu, HOLD, 2'd0, "lu1");
        step(idle, NONE, 2'd0, "lu1_after");
        chk("lu1.count", 32'(stall_cycles), 32'd1);

        // Branch on load in EX: RUN -> BR_WAIT -> RUN, then redirect flushes.
        do_reset();
        step(brlu, HOLD, 2'd0, "brl_c1");
        step(br_mem, HOLD, 2'd1, "brl_c2");
        step(rd_only, FL, 2'd0, "brl_c3");
        chk("brl.count", 32'(stall_cycles), 32'd2);

        // Memory wait of 3 cycles, then the pipeline advances.
        do_reset();
        step(w, FRZ, 2'd0, "mw_c1");
        step(w, FRZ, 2'd2, "mw_c2");
        step(w, FRZ, 2'd2, "mw_c3");
        step(wr, NONE, 2'd2, "mw_exit");
        step(idle, NONE, 2'd0, "mw_after");
        chk("mw.count", 32'(stall_cycles), 32'd3);

        // Memory wait with a pending load-use: stall follows the wait.
        do_reset();
        step(lu_w, FRZ, 2'd0, "mwlu_c1");
        step(lu_w, FRZ, 2'd2, "mwlu_c2");
        step(lu_w, FRZ, 2'd2, "mwlu_c3");
        step(lu_r, NONE, 2'd2, "mwlu_exit");
        step(lu, HOLD, 2'd0, "mwlu_stall");
        step(idle, NONE, 2'd0, "mwlu_after");

        // Timeout after the 4th MEM_WAIT cycle, sticky, cleared by reset.
        do_reset();
        step(w, FRZ, 2'd0, "to_entry");
        for (int k = 0; k < 3; k++) step(w, FRZ, 2'd2, "to_wait");
        chk("to.before", 32'(mem_timeout), 32'd0);
        step(w, FRZ, 2'd2, "to_wait4");
        chk("to.set", 32'(mem_timeout), 32'd1);
        step(w, FRZ, 2'd2, "to_wait5");
        step(wr, NONE, 2'd2, "to_exit");
        step(idle, NONE, 2'd0, "to_after");
        chk("to.sticky", 32'(mem_timeout), 32'd1);
        step(w, FRZ, 2'd0, "to_again");
        step(w, FRZ, 2'd2, "to_again2");
        @(negedge clk);
        drive(w);
        rst = 1'b1;
        #1;
        chk("rst_mw.state", 32'(hz_state), 32'd0);
        chk("rst_mw.timeout", 32'(mem_timeout), 32'd0);
        chk("rst_mw.count", 32'(stall_cycles), 32'd0);
        chk("rst_mw.ctrl", 32'(dut_ctrl()), 32'(FRZ));
        @(negedge clk);
        rst = 1'b0;
        drive(idle);

        // Reset while in BR_WAIT returns to RUN immediately.
        step(brlu, HOLD, 2'd0, "rst_br_c1");
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        #1;
        chk("rst_br.state", 32'(hz_state), 32'd0);
        chk("rst_br.ctrl", 32'(dut_ctrl()), 32'(NONE));
        chk("rst_br.count", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Counter saturation: 10 load-use stalls with a 3-bit counter.
        do_reset();
        for (int k = 0; k < 10; k++) step(lu, HOLD, 2'd0, "sat");
        chk("sat.count", 32'(stall_cycles), 32'd7);

        // Randomized stimulus against the behavioural model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            in_t v;
            logic [6:0] ec;
            bit r;
            @(negedge clk);
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.rdex  = 5'($urandom_range(0, 3));
            v.rdmem = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.mrex  = 1'($urandom_range(0, 1));
            v.mrmem = 1'($urandom_range(0, 1));
            v.br    = ($urandom_range(0, 9) < 3);
            v.redir = ($urandom_range(0, 9) < 3);
            v.req   = ($urandom_range(0, 9) < 3);
            v.rdy   = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 99) == 0);
            rst = r;
            drive(v);
            #1;
            if (r) model_reset();
            ec = model_ctrl(v);
            chk("rand.ctrl", 32'(dut_ctrl()), 32'(ec));
            chk("rand.state", 32'(hz_state), 32'(model_state()));
            chk("rand.timeout", 32'(mem_timeout), 32'(m_to));
            chk("rand.count", 32'(stall_cycles), 32'(m_cnt));
            if (!r) model_update(v, ec);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
